// File: rtl/lrf_frame_source.sv
// Streams FRAMES_PER_RUN frames out of a frame store onto AXI-Stream.
// Reads are credit-limited so a 2-entry output FIFO can never overflow.
module lrf_frame_source #(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 64,
  parameter int unsigned N_FUSE_COUNT    = 4,
  parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  localparam int unsigned FRAMES_PER_RUN  = 2 << N_FUSE_COUNT,
  localparam int unsigned BEATS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
  localparam int unsigned FRAME_W         = $clog2(FRAMES_PER_RUN),
  localparam int unsigned BEAT_W          = $clog2(BEATS_PER_IMAGE),
  localparam int unsigned ADDR_W          = FRAME_W + BEAT_W
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_areset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [BEAT_W-1:0]  LastBeat  = BEAT_W'(BEATS_PER_IMAGE - 1);
  localparam logic [FRAME_W-1:0] LastFrame = FRAME_W'(FRAMES_PER_RUN - 1);

  logic [1:0]            state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  armed_q;
  logic                  inflight_q, infl_first_q, infl_last_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  fifo_first_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            count_q, count_d;

  logic       pop, push, room, start_ok, beat_last, frame_last, abort_now;
  logic [2:0] occ;

  always_comb begin
    pop        = (count_q != 2'd0) && m_axis_tready;
    push       = inflight_q;
    // Credit counts FIFO entries plus the read in flight, net of this cycle's pop.
    occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    room       = occ < 3'd2;
    start_ok   = (state_q == StIdle) && armed_q && start && !abort;
    mem_ren    = start_ok || ((state_q == StRun) && room);
    beat_last  = beat_q == LastBeat;
    frame_last = frame_q == LastFrame;
    abort_now  = abort_pend_q || ((state_q == StRun) && abort);

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun:   if (mem_ren && beat_last && (frame_last || abort_now)) state_d = StDrain;
      StDrain: if ((count_q == 2'd0) && !inflight_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    abort_pend_d = (state_d == StRun) && abort_now;

    beat_d  = beat_q;
    frame_d = frame_q;
    if (mem_ren) begin
      if (state_d == StDrain) begin
        // Final read of the run (or of an aborted run): park the address at 0.
        beat_d  = '0;
        frame_d = '0;
      end else if (beat_last) begin
        beat_d  = '0;
        frame_d = frame_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      frame_q      <= '0;
      abort_pend_q <= 1'b0;
      armed_q      <= 1'b0;
      inflight_q   <= 1'b0;
      infl_first_q <= 1'b0;
      infl_last_q  <= 1'b0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      count_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]  <= '0;
        fifo_last_q[i]  <= 1'b0;
        fifo_first_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      frame_q      <= frame_d;
      abort_pend_q <= abort_pend_d;
      armed_q      <= 1'b1;
      inflight_q   <= mem_ren;
      infl_first_q <= beat_q == '0;
      infl_last_q  <= beat_last;
      count_q      <= count_d;
      if (push) begin
        fifo_data_q[wptr_q]  <= mem_rdata;
        fifo_last_q[wptr_q]  <= infl_last_q;
        fifo_first_q[wptr_q] <= infl_first_q;
        wptr_q               <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end

  assign mem_raddr     = {frame_q, beat_q};
  assign m_axis_tvalid = count_q != 2'd0;
  assign m_axis_tdata  = fifo_data_q[rptr_q];
  assign m_axis_tlast  = fifo_last_q[rptr_q];
  assign m_axis_tuser  = fifo_first_q[rptr_q];
  assign busy          = state_q != StIdle;
  assign done          = state_q == StDone;

endmodule

// File: tb/tb_lrf_frame_source.sv
// Directed and randomized bench for lrf_frame_source (4 beats/frame, 2 frames/run).
module tb_lrf_frame_source;

  localparam int unsigned PPB   = 16;
  localparam int unsigned DIM   = 8;
  localparam int unsigned NFUSE = 0;
  localparam int unsigned DW    = 8 * PPB;
  localparam int unsigned AW    = 3;
  localparam int          BPI   = DIM * DIM / PPB;
  localparam int          TOTAL = (2 << NFUSE) * BPI;

  logic          clk = 1'b0;
  logic          rst, start, abort, tready;
  logic          mem_ren, tvalid, tlast, tuser, busy, done;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata, tdata;

  int errors = 0;
  int checks = 0;

  lrf_frame_source #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM      (DIM),
    .N_FUSE_COUNT   (NFUSE)
  ) dut (
    .m_axis_aclk  (clk),
    .m_axis_areset(rst),
    .start        (start),
    .abort        (abort),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .m_axis_tuser (tuser),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Frame store: each word holds its own address; junk when not read.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= DW'(mem_raddr);
    else         mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One run from the current cycle. mode 0: tready=1, 1: toggling, 2: random.
  // abort_at >= 1 raises abort in the cycle that address is read.
  task automatic do_run(input int mode, input int abort_at, input bit poke);
    int            n_exp, first_v, done_cyc, issued, acc, e, cyc;
    int            exp_q[$];
    bit            pv, pr, seen_done, acc_now;
    logic [DW-1:0] pd;
    logic          pl, pu;
    n_exp = (abort_at < 0) ? TOTAL : ((abort_at / BPI) + 1) * BPI;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(i);
    first_v = -1; done_cyc = -1; issued = 0; acc = 0;
    pv = 0; pr = 0; pd = '0; pl = 0; pu = 0; seen_done = 0;
    for (cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      case (mode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 2) == 0;
        default: tready = 1'($urandom % 2);
      endcase
      start = (cyc == 0) || (poke && cyc == 3);
      #1;
      abort = (abort_at >= 0) && mem_ren && (int'(mem_raddr) == abort_at);
      @(negedge clk);
      acc_now = tvalid && tready;
      if (mem_ren) begin
        chk("raddr_order", DW'(mem_raddr), DW'(issued));
        chk("raddr_bound", DW'(issued < n_exp), DW'(1));
        chk("credit", DW'((issued - acc - int'(acc_now)) < 2), DW'(1));
        issued++;
      end
      if (pv && !pr) begin
        chk("hold_valid", DW'(tvalid), DW'(1));
        chk("hold_data", tdata, pd);
        chk("hold_last", DW'(tlast), DW'(pl));
        chk("hold_user", DW'(tuser), DW'(pu));
      end
      if (tvalid && first_v < 0) first_v = cyc;
      if (acc_now) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("tdata", tdata, DW'(e));
        chk("tlast", DW'(tlast), DW'((e % BPI) == BPI - 1));
        chk("tuser", DW'(tuser), DW'((e % BPI) == 0));
        if (mode == 0) chk("full_rate", DW'(cyc), DW'(acc + 2));
        acc++;
      end
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
      end
      pv = tvalid; pr = tready; pd = tdata; pl = tlast; pu = tuser;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
    end
    chk("done_seen", DW'(seen_done), DW'(1));
    chk("all_beats", DW'(exp_q.size()), DW'(0));
    chk("latency", DW'(first_v), DW'(2));
    if (mode == 0) chk("done_cycle", DW'(done_cyc), DW'(n_exp + 3));
    chk("done_pulse", DW'(done), DW'(0));
    chk("idle_after", DW'(busy), DW'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tready = 1'b0;
    #3;
    chk("rst_tvalid", DW'(tvalid), DW'(0));
    chk("rst_tlast", DW'(tlast), DW'(0));
    chk("rst_tuser", DW'(tuser), DW'(0));
    chk("rst_ren", DW'(mem_ren), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_raddr", DW'(mem_raddr), DW'(0));
    chk("rst_tdata", tdata, DW'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1;
    #1 chk("idle_abort_ren", DW'(mem_ren), DW'(0));
    @(posedge clk);
    #1 chk("idle_abort_busy", DW'(busy), DW'(0));
    start = 1'b0; abort = 1'b0;

    do_run(0, -1, 1'b0);   // full rate
    do_run(1, -1, 1'b0);   // toggling backpressure
    do_run(0, 1, 1'b0);    // abort on beat 1 of frame 0
    do_run(0, 3, 1'b0);    // abort on the frame's last read
    do_run(0, 5, 1'b0);    // abort inside frame 1
    do_run(0, -1, 1'b1);   // start during RUN is ignored...
    do_run(0, -1, 1'b0);   // ...and a start right after done restarts
    for (int r = 0; r < 4; r++)
      do_run(2, (($urandom % 2) != 0) ? int'($urandom_range(7, 1)) : -1, 1'b0);

    // Reset with two beats buffered.
    tready = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_valid", DW'(tvalid), DW'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_tvalid", DW'(tvalid), DW'(0));
    chk("async_busy", DW'(busy), DW'(0));
    chk("async_ren", DW'(mem_ren), DW'(0));
    chk("async_done", DW'(done), DW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_run(0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
